xres_sequencer: RTL and testbench



---
 rtl/xres_sequencer_if.sv | 48 ++++
 rtl/xres_sequencer.sv | 132 +++++++++++++
 tb/tb_xres_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/xres_sequencer_if.sv
// XRES sequencer pad/config/reset bundle.
// slave side belongs to the sequencer, master side to its environment.
interface xres_sequencer_if #(
  parameter int DEBOUNCE_W = 8
);
  logic                  xres_n_i;
  logic [DEBOUNCE_W-1:0] cfg_debounce;
  logic                  cfg_filt_en;
  logic                  cfg_pullup_dis;
  logic                  pad_enable_h;
  logic                  pad_en_vddio_sig_h;
  logic                  pad_filt_in_h;
  logic                  pad_inp_sel_h;
  logic                  pad_disable_pullup_h;
  logic [2:0]            rst_stage_n;
  logic                  seq_busy;
  logic                  xres_event;

  modport slave (
    input  xres_n_i,
    input  cfg_debounce,
    input  cfg_filt_en,
    input  cfg_pullup_dis,
    output pad_enable_h,
    output pad_en_vddio_sig_h,
    output pad_filt_in_h,
    output pad_inp_sel_h,
    output pad_disable_pullup_h,
    output rst_stage_n,
    output seq_busy,
    output xres_event
  );

  modport master (
    output xres_n_i,
    output cfg_debounce,
    output cfg_filt_en,
    output cfg_pullup_dis,
    input  pad_enable_h,
    input  pad_en_vddio_sig_h,
    input  pad_filt_in_h,
    input  pad_inp_sel_h,
    input  pad_disable_pullup_h,
    input  rst_stage_n,
    input  seq_busy,
    input  xres_event
  );
endinterface

// File: rtl/xres_sequencer.sv
// XRES pad power-up sequencing, XRES_H_N debounce
// and staged core reset release.
module xres_sequencer #(
  parameter int DEBOUNCE_W  = 8,
  parameter int STAGE_DLY   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  xres_sequencer_if.slave bus
);

  localparam int WCW = $clog2(STAGE_DLY + 1);

  typedef enum logic [3:0] {
    INIT, PAD_EN, FILT, WAIT,
    REL0, REL1, REL2, RUN, HOLD
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  s;
  logic                  deb_q;
  logic [DEBOUNCE_W-1:0] cnt_q;
  logic [DEBOUNCE_W:0]   cnt_inc;
  logic [DEBOUNCE_W:0]   thr;
  logic [WCW-1:0]        wc_q;
  logic                  wc_done;
  logic                  filt_q;
  logic                  pull_q;
  logic                  ev_q;
  logic [2:0]            rst_n;

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign thr     = (bus.cfg_debounce == '0)
                 ? (DEBOUNCE_W+1)'(1)
                 : {1'b0, bus.cfg_debounce};
  assign wc_done = (wc_q == WCW'(STAGE_DLY - 1));

  // bring the asynchronous pad reset into the clock domain
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) sync_q <= '0;
    else          sync_q <= SYNC_STAGES'({sync_q, bus.xres_n_i});
  end

  // deb follows s only after a run of threshold stable samples
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else if (s != deb_q) begin
      if (cnt_inc >= thr) begin
        deb_q <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  // state, stage timer, latched pad config and event pulse
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= INIT;
      wc_q    <= '0;
      filt_q  <= 1'b0;
      pull_q  <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) wc_q <= '0;
      else if (!wc_done)      wc_q <= wc_q + 1'b1;
      if (state_q == PAD_EN && state_d == FILT) begin
        filt_q <= bus.cfg_filt_en;
        pull_q <= bus.cfg_pullup_dis;
      end
      ev_q <= (state_d == HOLD) && (state_q != HOLD);
    end
  end

  // next state; a debounced fall during release or run aborts to HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:   state_d = PAD_EN;
      PAD_EN: if (wc_done) state_d = FILT;
      FILT:   if (wc_done) state_d = WAIT;
      WAIT:   if (deb_q)   state_d = REL0;
      REL0: begin
        if (!deb_q)       state_d = HOLD;
        else if (wc_done) state_d = REL1;
      end
      REL1: begin
        if (!deb_q)       state_d = HOLD;
        else if (wc_done) state_d = REL2;
      end
      REL2: begin
        if (!deb_q)       state_d = HOLD;
        else if (wc_done) state_d = RUN;
      end
      RUN:    if (!deb_q)  state_d = HOLD;
      HOLD:   if (deb_q)   state_d = REL0;
      default: state_d = INIT;
    endcase
  end

  // staged core resets decoded from the state
  always_comb begin
    rst_n = 3'b000;
    unique case (state_q)
      REL0:    rst_n = 3'b001;
      REL1:    rst_n = 3'b011;
      REL2:    rst_n = 3'b111;
      RUN:     rst_n = 3'b111;
      default: rst_n = 3'b000;
    endcase
  end

  assign bus.pad_enable_h         = (state_q != INIT);
  assign bus.pad_en_vddio_sig_h   = (state_q != INIT);
  assign bus.pad_filt_in_h        = filt_q;
  assign bus.pad_inp_sel_h        = filt_q;
  assign bus.pad_disable_pullup_h = pull_q;
  assign bus.rst_stage_n          = rst_n;
  assign bus.seq_busy             = (state_q != RUN);
  assign bus.xres_event           = ev_q;

endmodule

// File: tb/tb_xres_sequencer.sv
// Scoreboard bench for xres_sequencer: expected output
// changes are queued with their cycle, a monitor pops them.
module tb_xres_sequencer;

  typedef struct {
    int         c;
    logic [9:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t me;
  logic [9:0] cur;
  logic [9:0] prev;

  xres_sequencer_if #(.DEBOUNCE_W(8)) bus ();

  xres_sequencer #(
    .DEBOUNCE_W (8),
    .STAGE_DLY  (16),
    .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  assign cur = {bus.pad_enable_h, bus.pad_en_vddio_sig_h,
                bus.pad_filt_in_h, bus.pad_inp_sel_h,
                bus.pad_disable_pullup_h, bus.rst_stage_n,
                bus.seq_busy, bus.xres_event};

  function automatic logic [9:0] ov(bit en, bit fl, bit pu,
                                    logic [2:0] r, bit bz, bit ev);
    return {en, en, fl, fl, pu, r, bz, ev};
  endfunction

  task automatic push(int c, logic [9:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_rst(string nm);
    tests++;
    if (cur !== ov(0, 0, 0, 3'b000, 1, 0)) begin
      fails++;
      $display("FAIL %s got=%b want=%b", nm, cur,
               ov(0, 0, 0, 3'b000, 1, 0));
    end
  endtask

  task automatic chk_empty(string nm);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s pending=%0d want=0", nm, q.size());
    end
  endtask

  // monitor: every output change must match the next queued entry
  always @(negedge clk) begin
    if (rst) begin
      prev = cur;
    end else begin
      if (cur !== prev) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got=%b want=none",
                   cyc, cur);
        end else begin
          me = q.pop_front();
          if (me.c != cyc || me.v !== cur) begin
            fails++;
            $display("FAIL seq got=%b@%0d want=%b@%0d",
                     cur, cyc, me.v, me.c);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    bus.xres_n_i       = 1'b1;
    bus.cfg_debounce   = 8'd4;
    bus.cfg_filt_en    = 1'b1;
    bus.cfg_pullup_dis = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.xres_n_i       = 1'($urandom);
      bus.cfg_debounce   = 8'($urandom);
      bus.cfg_filt_en    = 1'($urandom);
      bus.cfg_pullup_dis = 1'($urandom);
      @(negedge clk);
      chk_rst("rst_hold");
    end

    // power-up: filter on, pull-up enabled
    bus.xres_n_i       = 1'b1;
    bus.cfg_debounce   = 8'd4;
    bus.cfg_filt_en    = 1'b1;
    bus.cfg_pullup_dis = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    push(1,  ov(1, 0, 0, 3'b000, 1, 0));
    push(17, ov(1, 1, 0, 3'b000, 1, 0));
    push(34, ov(1, 1, 0, 3'b001, 1, 0));
    push(50, ov(1, 1, 0, 3'b011, 1, 0));
    push(66, ov(1, 1, 0, 3'b111, 1, 0));
    push(82, ov(1, 1, 0, 3'b111, 0, 0));

    // latched config must not follow later changes
    wait_cyc(20);
    bus.cfg_filt_en = 1'b0;
    wait_cyc(25);
    bus.cfg_pullup_dis = 1'b1;

    // 3-cycle glitch: nothing expected
    wait_cyc(90);
    bus.xres_n_i = 1'b0;
    wait_cyc(93);
    bus.xres_n_i = 1'b1;

    // valid reset of 40 cycles
    wait_cyc(100);
    push(107, ov(1, 1, 0, 3'b000, 1, 1));
    push(108, ov(1, 1, 0, 3'b000, 1, 0));
    push(147, ov(1, 1, 0, 3'b001, 1, 0));
    push(163, ov(1, 1, 0, 3'b011, 1, 0));
    push(179, ov(1, 1, 0, 3'b111, 1, 0));
    push(195, ov(1, 1, 0, 3'b111, 0, 0));
    bus.xres_n_i = 1'b0;
    wait_cyc(140);
    bus.xres_n_i = 1'b1;

    // reset, release, then abort during REL1
    wait_cyc(200);
    push(207, ov(1, 1, 0, 3'b000, 1, 1));
    push(208, ov(1, 1, 0, 3'b000, 1, 0));
    push(217, ov(1, 1, 0, 3'b001, 1, 0));
    push(233, ov(1, 1, 0, 3'b011, 1, 0));
    push(242, ov(1, 1, 0, 3'b000, 1, 1));
    push(243, ov(1, 1, 0, 3'b000, 1, 0));
    push(257, ov(1, 1, 0, 3'b001, 1, 0));
    push(273, ov(1, 1, 0, 3'b011, 1, 0));
    push(289, ov(1, 1, 0, 3'b111, 1, 0));
    push(305, ov(1, 1, 0, 3'b111, 0, 0));
    bus.xres_n_i = 1'b0;
    wait_cyc(210);
    bus.xres_n_i = 1'b1;
    wait_cyc(235);
    bus.xres_n_i = 1'b0;
    wait_cyc(250);
    bus.xres_n_i = 1'b1;

    // zero debounce behaves as one sample
    wait_cyc(310);
    bus.cfg_debounce = 8'd0;
    wait_cyc(320);
    push(324, ov(1, 1, 0, 3'b000, 1, 1));
    push(325, ov(1, 1, 0, 3'b000, 1, 0));
    push(334, ov(1, 1, 0, 3'b001, 1, 0));
    push(350, ov(1, 1, 0, 3'b011, 1, 0));
    push(366, ov(1, 1, 0, 3'b111, 1, 0));
    push(382, ov(1, 1, 0, 3'b111, 0, 0));
    bus.xres_n_i = 1'b0;
    wait_cyc(330);
    bus.xres_n_i = 1'b1;

    wait_cyc(390);
    chk_empty("phase1_drain");

    // asynchronous reset in RUN, checked before any clock edge
    #2 rst = 1'b1;
    #1 chk_rst("async_rst");
    for (int i = 0; i < 2; i++) begin
      bus.xres_n_i     = 1'($urandom);
      bus.cfg_debounce = 8'($urandom);
      @(negedge clk);
      chk_rst("rst_hold2");
    end

    // second power-up: pull-up disabled, no filter,
    // deb falls in PAD_EN and stays low into WAIT
    bus.xres_n_i       = 1'b1;
    bus.cfg_debounce   = 8'd4;
    bus.cfg_filt_en    = 1'b0;
    bus.cfg_pullup_dis = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    push(1,  ov(1, 0, 0, 3'b000, 1, 0));
    push(17, ov(1, 0, 1, 3'b000, 1, 0));
    push(47, ov(1, 0, 1, 3'b001, 1, 0));
    push(63, ov(1, 0, 1, 3'b011, 1, 0));
    push(79, ov(1, 0, 1, 3'b111, 1, 0));
    push(95, ov(1, 0, 1, 3'b111, 0, 0));
    wait_cyc(8);
    bus.xres_n_i = 1'b0;
    wait_cyc(40);
    bus.xres_n_i = 1'b1;
    wait_cyc(110);
    chk_empty("phase2_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
